// File: rtl/ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS-subset controller: opcodes, FSM
// states, PC-select and ALU function codes, and the decoded instruction record.
package ctrl_pkg;

  localparam logic [5:0] OP_ADD   = 6'b000000;
  localparam logic [5:0] OP_SUB   = 6'b000001;
  localparam logic [5:0] OP_ADDIU = 6'b000010;
  localparam logic [5:0] OP_AND   = 6'b010000;
  localparam logic [5:0] OP_ANDI  = 6'b010001;
  localparam logic [5:0] OP_OR    = 6'b010010;
  localparam logic [5:0] OP_ORI   = 6'b010011;
  localparam logic [5:0] OP_SLL   = 6'b011000;
  localparam logic [5:0] OP_SLTI  = 6'b011100;
  localparam logic [5:0] OP_SW    = 6'b100110;
  localparam logic [5:0] OP_LW    = 6'b100111;
  localparam logic [5:0] OP_BEQ   = 6'b110000;
  localparam logic [5:0] OP_BNE   = 6'b110001;
  localparam logic [5:0] OP_BLTZ  = 6'b110010;
  localparam logic [5:0] OP_J     = 6'b111000;
  localparam logic [5:0] OP_JR    = 6'b111001;
  localparam logic [5:0] OP_JAL   = 6'b111010;
  localparam logic [5:0] OP_HALT  = 6'b111111;

  typedef enum logic [3:0] {
    S_IF     = 4'd0,
    S_ID     = 4'd1,
    S_EXE_AL = 4'd2,
    S_WB_AL  = 4'd3,
    S_EXE_BR = 4'd4,
    S_EXE_LS = 4'd5,
    S_MEM    = 4'd6,
    S_WB_L   = 4'd7,
    S_HALT   = 4'd8
  } state_e;

  localparam logic [1:0] PC_INC = 2'b00;
  localparam logic [1:0] PC_BR  = 2'b01;
  localparam logic [1:0] PC_RS  = 2'b10;
  localparam logic [1:0] PC_JMP = 2'b11;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_SLL = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_AND = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b110;

  localparam logic [1:0] RD_RA = 2'b00;
  localparam logic [1:0] RD_RT = 2'b01;
  localparam logic [1:0] RD_RD = 2'b10;

  typedef enum logic [3:0] {
    C_ALU, C_BEQ, C_BNE, C_BLTZ, C_LW, C_SW, C_J, C_JR, C_JAL, C_HALT
  } iclass_e;

  typedef struct packed {
    iclass_e    cls;
    logic [2:0] aluop;
    logic       ext_sel;
    logic       alusrc_a;
    logic       alusrc_b;
    logic [1:0] reg_dst;
    logic       db_src;
    logic       wr_src;
  } dec_t;

  // Select values driven whenever no instruction is being decoded; also the
  // decode of halt and of every unrecognised opcode.
  localparam dec_t DEC_IDLE = '{cls: C_HALT, aluop: ALU_ADD, ext_sel: 1'b1,
                                alusrc_a: 1'b0, alusrc_b: 1'b0, reg_dst: RD_RT,
                                db_src: 1'b0, wr_src: 1'b1};

  function automatic logic br_taken(iclass_e cls, logic zero, logic sign);
    return (cls == C_BEQ && zero) || (cls == C_BNE && !zero) ||
           (cls == C_BLTZ && sign);
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode decoder: instruction class plus the per-opcode datapath
// selects. jal is recognised only when JAL_INSN_EN is defined.
module ctrl_decode import ctrl_pkg::*; (
  input  logic [5:0] op,
  output dec_t       dec
);

  always_comb begin
    dec = DEC_IDLE;
    case (op)
      OP_ADD: begin
        dec.cls = C_ALU; dec.aluop = ALU_ADD; dec.reg_dst = RD_RD;
      end
      OP_SUB: begin
        dec.cls = C_ALU; dec.aluop = ALU_SUB; dec.reg_dst = RD_RD;
      end
      OP_ADDIU: begin
        dec.cls = C_ALU; dec.aluop = ALU_ADD; dec.alusrc_b = 1'b1;
      end
      OP_AND: begin
        dec.cls = C_ALU; dec.aluop = ALU_AND; dec.reg_dst = RD_RD;
      end
      OP_ANDI: begin
        dec.cls = C_ALU; dec.aluop = ALU_AND; dec.alusrc_b = 1'b1;
        dec.ext_sel = 1'b0;
      end
      OP_OR: begin
        dec.cls = C_ALU; dec.aluop = ALU_OR; dec.reg_dst = RD_RD;
      end
      OP_ORI: begin
        dec.cls = C_ALU; dec.aluop = ALU_OR; dec.alusrc_b = 1'b1;
        dec.ext_sel = 1'b0;
      end
      OP_SLL: begin
        dec.cls = C_ALU; dec.aluop = ALU_SLL; dec.alusrc_a = 1'b1;
        dec.reg_dst = RD_RD;
      end
      OP_SLTI: begin
        dec.cls = C_ALU; dec.aluop = ALU_SLT; dec.alusrc_b = 1'b1;
      end
      OP_LW: begin
        dec.cls = C_LW; dec.alusrc_b = 1'b1; dec.db_src = 1'b1;
      end
      OP_SW: begin
        dec.cls = C_SW; dec.alusrc_b = 1'b1;
      end
      // Branches compare through subtraction; bltz reads the result sign.
      OP_BEQ:  begin dec.cls = C_BEQ;  dec.aluop = ALU_SUB; end
      OP_BNE:  begin dec.cls = C_BNE;  dec.aluop = ALU_SUB; end
      OP_BLTZ: begin dec.cls = C_BLTZ; dec.aluop = ALU_SUB; end
      OP_J:    dec.cls = C_J;
      OP_JR:   dec.cls = C_JR;
`ifdef JAL_INSN_EN
      OP_JAL: begin
        dec.cls = C_JAL; dec.reg_dst = RD_RA; dec.wr_src = 1'b0;
      end
`endif
      default: dec = DEC_IDLE;
    endcase
  end

endmodule

// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle controller FSM (IF/ID/EXE/MEM/WB) driving the datapath strobes.
// Define JAL_INSN_EN to support jal; otherwise its opcode halts the machine.
module multi_cycle_ctrl import ctrl_pkg::*; (
  input  logic       CLK,
  input  logic       Reset,
  input  logic [5:0] op,
  input  logic       zero,
  input  logic       sign,
  output logic [1:0] PCSrc,
  output logic       PCWre,
  output logic       IRWre,
  output logic       RegWre,
  output logic       mRD,
  output logic       mWR,
  output logic       ALUSrcA,
  output logic       ALUSrcB,
  output logic       ExtSel,
  output logic       DBDataSrc,
  output logic       WrRegDSrc,
  output logic [1:0] RegDst,
  output logic [2:0] ALUOp,
  output logic [3:0] state
);

  dec_t   dec;
  dec_t   sel;
  state_e st;
  logic   rst_q;

  ctrl_decode u_decode (
    .op  (op),
    .dec (dec)
  );

  // rst_q marks the cycle after a reset edge: the machine sits in sIF with
  // every strobe low, so IR is not loaded until the following cycle.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      st    <= S_IF;
      rst_q <= 1'b1;
    end else begin
      rst_q <= 1'b0;
      if (!rst_q) begin
        case (st)
          S_IF: st <= S_ID;
          S_ID: begin
            case (dec.cls)
              C_ALU:               st <= S_EXE_AL;
              C_BEQ, C_BNE, C_BLTZ: st <= S_EXE_BR;
              C_LW, C_SW:          st <= S_EXE_LS;
              C_J, C_JR, C_JAL:    st <= S_IF;
              default:             st <= S_HALT;
            endcase
          end
          S_EXE_AL: st <= S_WB_AL;
          S_WB_AL:  st <= S_IF;
          S_EXE_BR: st <= S_IF;
          S_EXE_LS: st <= S_MEM;
          S_MEM:    st <= (dec.cls == C_LW) ? S_WB_L : S_IF;
          S_WB_L:   st <= S_IF;
          default:  st <= S_HALT;
        endcase
      end
    end
  end

  assign state = st;

  // op is the IR field, valid from sID onward; in sIF it still holds the
  // previous instruction, so selects fall back to idle values there.
  always_comb begin
    sel = dec;
    if (rst_q || st == S_IF || st == S_HALT) sel = DEC_IDLE;
  end

  assign ALUSrcA   = sel.alusrc_a;
  assign ALUSrcB   = sel.alusrc_b;
  assign ExtSel    = sel.ext_sel;
  assign DBDataSrc = sel.db_src;
  assign WrRegDSrc = sel.wr_src;
  assign RegDst    = sel.reg_dst;
  assign ALUOp     = sel.aluop;

  always_comb begin
    PCSrc  = PC_INC;
    PCWre  = 1'b0;
    IRWre  = 1'b0;
    RegWre = 1'b0;
    mRD    = 1'b0;
    mWR    = 1'b0;
    if (!rst_q) begin
      case (st)
        S_IF: IRWre = 1'b1;
        S_ID: begin
          case (dec.cls)
            C_J: begin
              PCWre = 1'b1; PCSrc = PC_JMP;
            end
            C_JR: begin
              PCWre = 1'b1; PCSrc = PC_RS;
            end
            C_JAL: begin
              PCWre = 1'b1; PCSrc = PC_JMP; RegWre = 1'b1;
            end
            default: PCWre = 1'b0;
          endcase
        end
        S_WB_AL, S_WB_L: begin
          RegWre = 1'b1;
          PCWre  = 1'b1;
        end
        // Only output that follows the live ALU flags.
        S_EXE_BR: begin
          PCWre = 1'b1;
          if (br_taken(dec.cls, zero, sign)) PCSrc = PC_BR;
        end
        S_MEM: begin
          if (dec.cls == C_SW) begin
            mWR   = 1'b1;
            PCWre = 1'b1;
          end else begin
            mRD = 1'b1;
          end
        end
        default: PCWre = 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Self-checking bench for multi_cycle_ctrl: directed and random instruction
// streams compared cycle by cycle against a per-instruction trace model.
module tb_multi_cycle_ctrl;

  logic       CLK = 1'b0;
  logic       Reset = 1'b1;
  logic [5:0] op = 6'd0;
  logic       zero = 1'b0;
  logic       sign = 1'b0;
  logic [1:0] PCSrc;
  logic       PCWre, IRWre, RegWre, mRD, mWR;
  logic       ALUSrcA, ALUSrcB, ExtSel, DBDataSrc, WrRegDSrc;
  logic [1:0] RegDst;
  logic [2:0] ALUOp;
  logic [3:0] state;

  int checks = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  multi_cycle_ctrl dut (
    .CLK(CLK), .Reset(Reset), .op(op), .zero(zero), .sign(sign),
    .PCSrc(PCSrc), .PCWre(PCWre), .IRWre(IRWre), .RegWre(RegWre),
    .mRD(mRD), .mWR(mWR), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ExtSel(ExtSel), .DBDataSrc(DBDataSrc), .WrRegDSrc(WrRegDSrc),
    .RegDst(RegDst), .ALUOp(ALUOp), .state(state)
  );

  logic [20:0] obs;
  assign obs = {state, PCSrc, PCWre, IRWre, RegWre, mRD, mWR,
                ALUSrcA, ALUSrcB, ExtSel, DBDataSrc, WrRegDSrc, RegDst, ALUOp};

  localparam logic [3:0] TS_IF = 4'd0, TS_ID = 4'd1, TS_EAL = 4'd2,
                         TS_WAL = 4'd3, TS_EBR = 4'd4, TS_ELS = 4'd5,
                         TS_MEM = 4'd6, TS_WL = 4'd7, TS_HLT = 4'd8;

  typedef enum logic [3:0] {
    K_ALU, K_BEQ, K_BNE, K_BLTZ, K_LW, K_SW, K_J, K_JR, K_JAL, K_HALT
  } kind_e;

  typedef struct packed {
    logic [5:0] op;
    kind_e      k;
    logic [2:0] aluop;
    logic       ext;
    logic       sa;
    logic       sb;
    logic [1:0] rd;
  } insn_t;

  localparam insn_t DEFI = '{op: 6'd0, k: K_HALT, aluop: 3'b000, ext: 1'b1,
                             sa: 1'b0, sb: 1'b0, rd: 2'b01};

  localparam logic [20:0] RST_VEC = {TS_IF, 2'b00, 5'b00000,
                                     1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'b01, 3'b000};

  insn_t tbl [18] = '{
    '{6'b000000, K_ALU,  3'b000, 1'b1, 1'b0, 1'b0, 2'b10},  // add
    '{6'b000001, K_ALU,  3'b001, 1'b1, 1'b0, 1'b0, 2'b10},  // sub
    '{6'b000010, K_ALU,  3'b000, 1'b1, 1'b0, 1'b1, 2'b01},  // addiu
    '{6'b010000, K_ALU,  3'b100, 1'b1, 1'b0, 1'b0, 2'b10},  // and
    '{6'b010001, K_ALU,  3'b100, 1'b0, 1'b0, 1'b1, 2'b01},  // andi
    '{6'b010010, K_ALU,  3'b011, 1'b1, 1'b0, 1'b0, 2'b10},  // or
    '{6'b010011, K_ALU,  3'b011, 1'b0, 1'b0, 1'b1, 2'b01},  // ori
    '{6'b011000, K_ALU,  3'b010, 1'b1, 1'b1, 1'b0, 2'b10},  // sll
    '{6'b011100, K_ALU,  3'b110, 1'b1, 1'b0, 1'b1, 2'b01},  // slti
    '{6'b100110, K_SW,   3'b000, 1'b1, 1'b0, 1'b1, 2'b01},  // sw
    '{6'b100111, K_LW,   3'b000, 1'b1, 1'b0, 1'b1, 2'b01},  // lw
    '{6'b110000, K_BEQ,  3'b001, 1'b1, 1'b0, 1'b0, 2'b01},  // beq
    '{6'b110001, K_BNE,  3'b001, 1'b1, 1'b0, 1'b0, 2'b01},  // bne
    '{6'b110010, K_BLTZ, 3'b001, 1'b1, 1'b0, 1'b0, 2'b01},  // bltz
    '{6'b111000, K_J,    3'b000, 1'b1, 1'b0, 1'b0, 2'b01},  // j
    '{6'b111001, K_JR,   3'b000, 1'b1, 1'b0, 1'b0, 2'b01},  // jr
    '{6'b111010, K_JAL,  3'b000, 1'b1, 1'b0, 1'b0, 2'b00},  // jal
    '{6'b111111, K_HALT, 3'b000, 1'b1, 1'b0, 1'b0, 2'b01}   // halt
  };

  function automatic insn_t lookup(logic [5:0] o);
    insn_t r = DEFI;
    r.op = o;
    foreach (tbl[i]) if (tbl[i].op == o) r = tbl[i];
`ifndef JAL_INSN_EN
    if (r.k == K_JAL) begin
      r = DEFI;
      r.op = o;
    end
`endif
    return r;
  endfunction

  // Cycles per instruction; halt is observed for a fixed window.
  function automatic int nlen(kind_e k);
    case (k)
      K_J, K_JR, K_JAL:     return 2;
      K_BEQ, K_BNE, K_BLTZ: return 3;
      K_ALU, K_SW:          return 4;
      K_LW:                 return 5;
      default:              return 12;
    endcase
  endfunction

  function automatic logic [3:0] state_at(kind_e k, int i);
    if (i == 0) return TS_IF;
    if (i == 1) return TS_ID;
    case (k)
      K_ALU:                return (i == 2) ? TS_EAL : TS_WAL;
      K_BEQ, K_BNE, K_BLTZ: return TS_EBR;
      K_LW:                 return (i == 2) ? TS_ELS : (i == 3) ? TS_MEM : TS_WL;
      K_SW:                 return (i == 2) ? TS_ELS : TS_MEM;
      default:              return TS_HLT;
    endcase
  endfunction

  function automatic logic [20:0] exp_vec(insn_t e, int i, int n, logic z, logic s);
    logic [3:0] st = state_at(e.k, i);
    logic fin = (i == n - 1) && (e.k != K_HALT);
    logic taken = (e.k == K_BEQ && z) || (e.k == K_BNE && !z) || (e.k == K_BLTZ && s);
    logic [1:0] pcs = 2'b00;
    logic regw = fin && (e.k == K_ALU || e.k == K_LW || e.k == K_JAL);
    logic mrd = (e.k == K_LW) && (i == 3);
    logic mwr = (e.k == K_SW) && fin;
    insn_t d = (i == 0 || st == TS_HLT) ? DEFI : e;
    if (fin) begin
      if (taken) pcs = 2'b01;
      else if (e.k == K_JR) pcs = 2'b10;
      else if (e.k == K_J || e.k == K_JAL) pcs = 2'b11;
    end
    return {st, pcs, fin, (i == 0), regw, mrd, mwr, d.sa, d.sb, d.ext,
            (d.k == K_LW), (d.k != K_JAL), d.rd, d.aluop};
  endfunction

  task automatic chk(input string tag, input logic [20:0] got, input logic [20:0] want);
    checks++;
    assert (got === want) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, got, want);
    end
  endtask

  // Holds Reset for `hold` edges, checking the idle state after each one.
  task automatic do_reset(input int hold);
    Reset = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(posedge CLK); #2;
      chk($sformatf("reset_c%0d", i), obs, RST_VEC);
    end
    Reset = 1'b0;
  endtask

  // Runs one instruction from its sIF cycle; stop>=0 ends early after that cycle.
  task automatic run_insn(input logic [5:0] o, input logic z, input logic s, input int stop);
    insn_t e = lookup(o);
    int n = nlen(e.k);
    for (int i = 0; i < n; i++) begin
      @(posedge CLK); #1;
      if (i == 0) op = o;
      zero = z;
      sign = s;
      #1;
      chk($sformatf("op%02h_c%0d", o, i), obs, exp_vec(e, i, n, z, s));
      if (i == stop) break;
    end
  endtask

  initial begin
    do_reset(3);
    run_insn(6'b000000, 1'b0, 1'b0, -1);   // add
    run_insn(6'b110000, 1'b1, 1'b0, -1);   // beq taken
    run_insn(6'b110000, 1'b0, 1'b1, -1);   // beq not taken
    run_insn(6'b110001, 1'b0, 1'b0, -1);   // bne taken
    run_insn(6'b110001, 1'b1, 1'b1, -1);   // bne not taken
    run_insn(6'b110010, 1'b0, 1'b1, -1);   // bltz taken
    run_insn(6'b110010, 1'b1, 1'b0, -1);   // bltz not taken
    run_insn(6'b100111, 1'b0, 1'b0, -1);   // lw
    run_insn(6'b100110, 1'b1, 1'b1, -1);   // sw
    run_insn(6'b111001, 1'b0, 1'b0, -1);   // jr
    run_insn(6'b111000, 1'b0, 1'b0, -1);   // j
    run_insn(6'b010001, 1'b0, 1'b0, -1);   // andi
    run_insn(6'b010011, 1'b1, 1'b0, -1);   // ori
    run_insn(6'b011000, 1'b0, 1'b1, -1);   // sll
    run_insn(6'b011100, 1'b0, 1'b0, -1);   // slti
    run_insn(6'b000010, 1'b0, 1'b0, -1);   // addiu
    run_insn(6'b000001, 1'b0, 1'b0, -1);   // sub
    run_insn(6'b010000, 1'b0, 1'b0, -1);   // and
    run_insn(6'b010010, 1'b0, 1'b0, -1);   // or
    run_insn(6'b111010, 1'b0, 1'b0, -1);   // jal (halts when not enabled)
`ifndef JAL_INSN_EN
    do_reset(1);
`endif
    run_insn(6'b100110, 1'b0, 1'b0, 3);    // sw, reset during sMEM
    do_reset(1);
    run_insn(6'b000000, 1'b0, 1'b0, 2);    // add, reset during sEXE_AL
    do_reset(2);
    run_insn(6'b111111, 1'b0, 1'b0, -1);   // halt
    do_reset(1);
    run_insn(6'b101010, 1'b1, 1'b1, -1);   // undefined opcode
    do_reset(1);

    for (int t = 0; t < 80; t++) begin
      logic [5:0] o;
      insn_t e;
      int stop;
      if ($urandom_range(0, 9) == 0) o = 6'($urandom);
      else o = tbl[$urandom_range(0, 17)].op;
      e = lookup(o);
      stop = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, nlen(e.k) - 1)) : -1;
      run_insn(o, 1'($urandom), 1'($urandom), stop);
      if (stop >= 0 || e.k == K_HALT) do_reset(int'($urandom_range(1, 2)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multi_cycle_ctrl.md
MULTI_CYCLE_CTRL -- requirements
Module: multi_cycle_ctrl

Interface
REQ-001 CLK  in  1  single clock; all state changes on rising edge.
REQ-002 Reset  in  1  synchronous, active-high reset.
REQ-003 op  in  6  opcode field of the instruction register (IR[31:26]).
REQ-004 zero  in  1  ALU result == 0, valid in EXE states.
REQ-005 sign  in  1  ALU result bit 31, valid in EXE states.
REQ-006 PCSrc  out  2  next-PC select to the 4:1 PC mux: 00 PC+4, 01 branch target, 10 rs (jr), 11 jump target.
REQ-007 PCWre  out  1  PC write enable.
REQ-008 IRWre  out  1  instruction register write enable.
REQ-009 RegWre  out  1  register file write enable.
REQ-010 mRD / mWR  out  1 each  data memory read / write strobe.
REQ-011 ALUSrcA, ALUSrcB, ExtSel, DBDataSrc, WrRegDSrc  out  1 each  datapath selects (sa/rs, imm/rt, sign/zero ext, mem/ALU, PC+4/DB).
REQ-012 RegDst  out  2  write-register select: 00 $31, 01 rt, 10 rd.
REQ-013 ALUOp  out  3  ALU function code.
REQ-014 state  out  4  current FSM state, for debug/bench.

Function
REQ-015 FSM states: sIF, sID, sEXE_AL, sWB_AL, sEXE_BR, sEXE_LS, sMEM, sWB_L, sHALT; Moore outputs except PCSrc (depends on zero/sign in sEXE_BR).
REQ-016 sIF -> sID always; IRWre=1 only in sIF.
REQ-017 sID: add/sub/addiu/and/andi/or/ori/sll/slti -> sEXE_AL; beq/bne/bltz -> sEXE_BR; lw/sw -> sEXE_LS; j/jr/jal -> sIF; halt -> sHALT; any undefined opcode -> sHALT.
REQ-018 sEXE_AL -> sWB_AL -> sIF; sEXE_BR -> sIF; sEXE_LS -> sMEM; sMEM -> sWB_L (lw) or sIF (sw); sWB_L -> sIF; sHALT -> sHALT.
REQ-019 Latency per instruction: jumps 2, branches 3, ALU ops and sw 4, lw 5 cycles.
REQ-020 PCWre=1 for exactly one cycle per instruction: the final state before sIF; 0 in sHALT.
REQ-021 PCSrc=00 except in the final cycle: beq&zero, bne&!zero, bltz&sign -> 01; jr -> 10; j/jal -> 11; untaken branch -> 00.
REQ-022 RegWre=1 only in sWB_AL, sWB_L, and sID for jal; mWR=1 only in sMEM for sw; mRD=1 only in sMEM for lw.
REQ-023 ALUOp per opcode held constant from sID through instruction end; codes from package.
REQ-024 ExtSel=0 (zero-extend) for andi/ori, 1 otherwise; ALUSrcA=1 only for sll; ALUSrcB=1 for immediate forms, lw, sw.

Reset
REQ-025 Reset=1 at a clock edge forces state=sIF and all enables 0, PCSrc=00 on the following cycle, including mid-instruction and from sHALT.
REQ-026 Reset overrides every transition; Reset held high keeps sIF with IRWre=0.

Configuration
REQ-027 Macro JAL_INSN_EN defined: jal supported (sID, RegWre=1, RegDst=00, WrRegDSrc=0, PCSrc=11, PCWre=1).
REQ-028 JAL_INSN_EN undefined: jal opcode decodes as undefined -> sHALT, no register write.

Structure
REQ-029 Package ctrl_pkg holds opcode constants, state encodings, PCSrc codes, ALUOp codes.
REQ-030 Sub-module ctrl_decode: combinational op -> instruction class + ALUOp/ExtSel/ALUSrc fields; FSM in top.

Verification
REQ-031 Reset, then add (op 000000) -> states IF,ID,EXE_AL,WB_AL,IF; RegWre=1 only in WB_AL; PCWre=1 in WB_AL, PCSrc=00.
REQ-032 beq with zero=1 -> PCSrc=01, PCWre=1 in sEXE_BR; with zero=0 -> PCSrc=00.
REQ-033 lw -> 5 cycles, mRD=1 in sMEM, RegWre=1 and DBDataSrc=1 in sWB_L; sw -> 4 cycles, mWR=1 in sMEM, RegWre never 1.
REQ-034 jr -> PCSrc=10, PCWre=1 in sID; jal with JAL_INSN_EN -> RegWre=1, RegDst=00, PCSrc=11; without -> sHALT.
REQ-035 Reset asserted in sMEM of sw -> next cycle sIF, mWR=0; halt opcode -> sHALT, PCWre stays 0 for 10+ cycles until Reset.
